srl_cfg_loader: RTL

Serial configuration loader for a bank of SRL16E truth-table cells. Accepts 16-bit LUT contents over a valid/ready handshake, shifts each word into the selected SRL16E through its D/CE pins, then optionally reads all 16 addresses back through the cell's Q/A pins to verify the load. Sits directly upstream of the SRL16E bank and owns its D, CE and, while loading, its A3..A0.

---
 rtl/srl_cfg_pkg.sv | 12 +
 rtl/srl_cfg_loader.sv | 111 +++++++++++
 2 files changed

// File: rtl/srl_cfg_pkg.sv
// Shared constants and FSM state type for the SRL16E configuration loader.
package srl_cfg_pkg;
  localparam int SRL_DEPTH  = 16;
  localparam int SRL_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/srl_cfg_loader.sv
// Shifts a 16-bit truth table MSB-first into one SRL16E of a bank, then
// optionally reads all 16 addresses back through Q to confirm the load.
module srl_cfg_loader
  import srl_cfg_pkg::*;
#(
  parameter int  NUM_LUTS  = 4,
  parameter bit  VERIFY_EN = 1'b1,
  localparam int IDX_W     = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [SRL_DEPTH-1:0]  cfg_word,
  output logic                  srl_d,
  output logic [NUM_LUTS-1:0]   srl_ce,
  output logic [SRL_ADDR_W-1:0] srl_addr,
  output logic                  srl_addr_sel,
  input  logic [NUM_LUTS-1:0]   srl_q,
  output logic                  done,
  output logic                  done_err,
  output logic                  busy
);

  state_e                  state_q, state_d;
  logic [SRL_ADDR_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SRL_DEPTH-1:0]    word_q, word_d;
  logic                    err_q, err_d;
  logic                    mis_q, mis_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          idx_d   = cfg_idx;
          word_d  = cfg_word;
          cnt_d   = '0;
          mis_d   = 1'b0;
          err_d   = (32'(cfg_idx) >= NUM_LUTS);
          state_d = err_d ? ST_RESP : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = VERIFY_EN ? ST_VERIFY : ST_RESP;
      end
      ST_VERIFY: begin
        cnt_d = cnt_q + 4'd1;
        mis_d = mis_q | (srl_q[idx_q] != word_q[cnt_q]);
        if (cnt_q == 4'd15) state_d = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    srl_ce       = '0;
    srl_d        = 1'b0;
    srl_addr     = '0;
    srl_addr_sel = 1'b0;
    done         = 1'b0;
    done_err     = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        srl_ce[idx_q] = 1'b1;
        srl_d         = word_q[~cnt_q]; // ~cnt == 15 - cnt: MSB enters first
      end
      ST_VERIFY: begin
        srl_addr_sel = 1'b1;
        srl_addr     = cnt_q;
      end
      ST_RESP: begin
        done     = 1'b1;
        done_err = err_q | mis_q;
      end
      default: ;
    endcase
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

endmodule
